// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and latency sequencer placing the CPU datapath (port 0)
// and the debug/DMA loader (port 1) onto the single-port 64-bit data memory.
module data_mem_arbiter #(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int MEM_LAT = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          grant_id
);

   localparam int CW = 4;
   localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          last_r, last_s;
   logic          owner_r, owner_s;
   logic          we_r, we_s;
   logic          pick_s;
   logic [AW-1:0] addr_r, addr_s;
   logic [DW-1:0] wdata_r, wdata_s;
   logic          grant_r, grant_s;
   logic          mem_wr_r, mem_wr_s;
   logic          ack0_r, ack0_s;
   logic          ack1_r, ack1_s;
   logic [DW-1:0] rdata0_r, rdata0_s;
   logic [DW-1:0] rdata1_r, rdata1_s;

   // Next-state and next-output decode; every output is re-registered below
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      last_s   = last_r;
      owner_s  = owner_r;
      we_s     = we_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      grant_s  = grant_r;
      rdata0_s = rdata0_r;
      rdata1_s = rdata1_r;
      pick_s   = 1'b0;
      mem_wr_s = 1'b0;
      ack0_s   = 1'b0;
      ack1_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the port that did not own the last access wins
               if (req0 && req1) begin
                  pick_s = ~last_r;
               end else begin
                  pick_s = req1;
               end
               owner_s  = pick_s;
               we_s     = pick_s ? we1    : we0;
               addr_s   = pick_s ? addr1  : addr0;
               wdata_s  = pick_s ? wdata1 : wdata0;
               grant_s  = pick_s;
               last_s   = pick_s;
               cnt_s    = LAT_INIT;
               mem_wr_s = pick_s ? we1 : we0;
               state_s  = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            cnt_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               if (!we_r && owner_r) begin
                  rdata1_s = mem_rdata;
               end else if (!we_r) begin
                  rdata0_s = mem_rdata;
               end else begin
                  rdata0_s = rdata0_r;
               end
               if (owner_r) begin
                  ack1_s = 1'b1;
               end else begin
                  ack0_s = 1'b1;
               end
               state_s = RESP;
            end else begin
               state_s = BUSY;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         last_r   <= 1'b1;
         owner_r  <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {AW{1'b0}};
         wdata_r  <= {DW{1'b0}};
         grant_r  <= 1'b0;
         mem_wr_r <= 1'b0;
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         rdata0_r <= {DW{1'b0}};
         rdata1_r <= {DW{1'b0}};
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         last_r   <= last_s;
         owner_r  <= owner_s;
         we_r     <= we_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         grant_r  <= grant_s;
         mem_wr_r <= mem_wr_s;
         ack0_r   <= ack0_s;
         ack1_r   <= ack1_s;
         rdata0_r <= rdata0_s;
         rdata1_r <= rdata1_s;
      end
   end

   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign mem_wr    = mem_wr_r;
   assign ack0      = ack0_r;
   assign ack1      = ack1_r;
   assign rdata0    = rdata0_r;
   assign rdata1    = rdata1_r;
   assign grant_id  = grant_r;
   assign busy      = (state_r != IDLE);

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the single-port 64-bit data memory (Memoria64).
- Port 0 is the multicycle CPU datapath, driven by the control state machine. Port 1 is a debug/DMA loader that preloads or inspects data memory while the core runs.
- Grants one access at a time with round-robin fairness, sequences the fixed memory latency and returns read data with a one-cycle ack.

Parameters:
- AW, 64, address width (byte address as used by the datapath)
- DW, 64, data width
- MEM_LAT, 2, cycles from address presented to memory read data valid; legal range 1..15

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- req0  in  1  CPU request; held with payload stable until ack0
- we0  in  1  CPU access is a write
- addr0  in  AW  CPU address
- wdata0  in  DW  CPU write data
- ack0  out  1  one-cycle completion pulse to CPU
- rdata0  out  DW  CPU read data; valid from the ack0 cycle until the next CPU read completes
- req1, we1, addr1, wdata1, ack1, rdata1  same directions, widths and meanings, for the loader
- mem_addr  out  AW  memory address (raddress and waddress)
- mem_wdata  out  DW  memory write data
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever the state is not IDLE
- grant_id  out  1  owner of the current or last access

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, cnt=0, last=1 (so port 0 wins the first tie).
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, grant_id=0.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- States:
  - IDLE: requests are sampled only here.
    - Only req0: grant port 0. Only req1: grant port 1.
    - Both: grant the port != last.
    - On the grant edge: latch owner, we, addr, wdata into internal regs; set grant_id=owner, last=owner, cnt=MEM_LAT; go BUSY.
    - No request: stay IDLE, all drives hold.
  - BUSY:
    - mem_addr and mem_wdata are driven from the latched regs.
    - mem_wr=1 only in the first BUSY cycle, and only when latched we=1. The strobe is exactly one cycle wide.
    - cnt decrements each edge.
    - On the edge where cnt==1:
      - Read: capture mem_rdata into the owner's rdata reg.
      - Write: the owner's rdata is unchanged.
      - Assert the owner's ack; go RESP.
  - RESP: the owner's ack=1 for exactly this one cycle; requests are ignored. Next edge: ack=0, go IDLE.
- Latency and throughput:
  - Request sampled at edge t0; ack is high in the cycle between edges t0+MEM_LAT and t0+MEM_LAT+1.
  - Each access occupies MEM_LAT+2 cycles.
- Requester rules:
  - Drop req at the edge that ends the ack cycle. A req still high in IDLE after that edge is a new access.
  - Dropping or changing req, addr or wdata while BUSY has no effect: the latched access completes and ack still pulses.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- Width rules: addresses and data pass unmodified; there is no alignment check (the memory handles byte addressing).
- Reset mid-operation:
  - The access is aborted and no ack is issued.
  - mem_wr drops immediately; a write already strobed may have completed in memory.
  - After reset deasserts, the FSM restarts in IDLE with last=1.
- ack0 and ack1 are never high in the same cycle. mem_wr is never high outside BUSY.

Test Plan:
- MEM_LAT=2; req0=1, we0=0, addr0=0x10 at t0; memory returns 0xDEADBEEF_00000001 → mem_addr=0x10 from t0; ack0 high in cycle t2–t3; rdata0=0xDEADBEEF_00000001; busy high for 3 cycles.
- req1=1, we1=1, addr1=0x20, wdata1=0x55 → mem_wr high exactly one cycle with mem_addr=0x20, mem_wdata=0x55; ack1 pulses once; rdata1 unchanged.
- req0 and req1 both rise together after reset and are re-asserted after every ack → grant_id sequence 0,1,0,1; ack0 and ack1 never coincide.
- req0 dropped and addr0 changed to 0x99 during BUSY → access to the original address completes; ack0 still pulses; no second access starts.
- RST pulled low during BUSY of a port-1 write → mem_wr=0 and ack1=0 immediately; after release, busy=0; the next simultaneous request is granted to port 0.
- MEM_LAT=1 build: single read → ack in the cycle right after the BUSY cycle; total occupancy 3 cycles.
